// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 16-bit pipelined MIPS.
//
// Owns the program counter and drives the instruction-memory address
// combinationally from it. The instruction returned in the same cycle is
// captured into the IF/ID pipeline register. A redirect from a later stage
// reloads the PC and squashes IF/ID. A flush squashes IF/ID only. A stall
// holds both the PC and IF/ID.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   stall           hold PC and IF/ID (load-use hazard)
//   flush           replace IF/ID with a bubble
//   redirect_valid  load PC from redirect_target and squash IF/ID
//   redirect_target new PC
//   imem_addr       instruction-memory read address (= pc)
//   imem_inst       instruction-memory read data (same-cycle read)
//   ifid_inst       registered instruction for decode
//   ifid_pc_plus1   registered pc+1 of that instruction
//   ifid_valid      IF/ID holds a real instruction
//   pc_out          current PC
//   fetch_cnt       (IF_PERF_CNT_EN) saturating count of real fetches
//   stall_cnt       (IF_PERF_CNT_EN) saturating count of stalled edges
//
// Build option
//   IF_PERF_CNT_EN  when defined, adds the fetch/stall performance counters.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int unsigned    AW       = 16,
  parameter int unsigned    DW       = 16,
  parameter logic [AW-1:0]  RESET_PC = 16'h0000,
  parameter logic [DW-1:0]  NOP_INST = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_target,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_inst,
  output logic [DW-1:0] ifid_inst,
  output logic [AW-1:0] ifid_pc_plus1,
  output logic          ifid_valid,
  output logic [AW-1:0] pc_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]   fetch_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ifid_inst;
  logic [AW-1:0] r_ifid_pc_plus1;
  logic          r_ifid_valid;

  logic [AW-1:0] w_pc_plus1;
  logic          w_fetch;

  // Wraps modulo 2^AW by width truncation.
  assign w_pc_plus1 = r_pc + AW'(1);

  // A real instruction is captured only when nothing higher-priority acts.
  assign w_fetch = !redirect_valid && !flush && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc            <= RESET_PC;
      r_ifid_inst     <= NOP_INST;
      r_ifid_pc_plus1 <= '0;
      r_ifid_valid    <= 1'b0;
    end else if (redirect_valid) begin
      // Wrong-path fetch in flight this cycle is dropped.
      r_pc            <= redirect_target;
      r_ifid_inst     <= NOP_INST;
      r_ifid_pc_plus1 <= '0;
      r_ifid_valid    <= 1'b0;
    end else if (flush) begin
      if (!stall) begin
        r_pc <= w_pc_plus1;
      end
      r_ifid_inst     <= NOP_INST;
      r_ifid_pc_plus1 <= '0;
      r_ifid_valid    <= 1'b0;
    end else if (w_fetch) begin
      r_pc            <= w_pc_plus1;
      r_ifid_inst     <= imem_inst;
      r_ifid_pc_plus1 <= w_pc_plus1;
      r_ifid_valid    <= 1'b1;
    end
  end

  assign imem_addr     = r_pc;
  assign pc_out        = r_pc;
  assign ifid_inst     = r_ifid_inst;
  assign ifid_pc_plus1 = r_ifid_pc_plus1;
  assign ifid_valid    = r_ifid_valid;

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fetch && (r_fetch_cnt != 16'hFFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
      // A stall that coincides with a redirect is not counted: the redirect wins.
      if (stall && !redirect_valid && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
// Instruction memory holds mem[k] = 16'h1000 + k. A behavioural model tracks
// PC and IF/ID from the priority rules and is compared after every edge.
// Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam logic [15:0] NOP = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          flush;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_inst;
  logic [DW-1:0] ifid_inst;
  logic [AW-1:0] ifid_pc_plus1;
  logic          ifid_valid;
  logic [AW-1:0] pc_out;
`ifdef IF_PERF_CNT_EN
  logic [15:0]   fetch_cnt;
  logic [15:0]   stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  logic [15:0] m_pc;
  logic [15:0] m_inst;
  logic [15:0] m_pp1;
  logic        m_valid;
  int          m_fcnt;
  int          m_scnt;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  assign imem_inst = mem_f(imem_addr);

  if_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_inst       (imem_inst),
    .ifid_inst       (ifid_inst),
    .ifid_pc_plus1   (ifid_pc_plus1),
    .ifid_valid      (ifid_valid),
    .pc_out          (pc_out)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_inst  = NOP;
    m_pp1   = 16'h0000;
    m_valid = 1'b0;
    m_fcnt  = 0;
    m_scnt  = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    32'(pc_out),        32'(m_pc));
    chk({tag, ".addr"},  32'(imem_addr),     32'(m_pc));
    chk({tag, ".inst"},  32'(ifid_inst),     32'(m_inst));
    chk({tag, ".pp1"},   32'(ifid_pc_plus1), 32'(m_pp1));
    chk({tag, ".valid"}, 32'(ifid_valid),    32'(m_valid));
`ifdef IF_PERF_CNT_EN
    chk({tag, ".fcnt"},  32'(fetch_cnt),     32'(m_fcnt));
    chk({tag, ".scnt"},  32'(stall_cnt),     32'(m_scnt));
`endif
  endtask

  // Called just after a rising edge; drives inputs, takes one edge, checks.
  task automatic step(input string tag, input logic s, input logic f,
                      input logic r, input logic [15:0] t);
    stall           = s;
    flush           = f;
    redirect_valid  = r;
    redirect_target = t;
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = t; m_inst = NOP; m_pp1 = 16'h0000; m_valid = 1'b0;
    end else if (f) begin
      if (!s) m_pc = m_pc + 16'd1;
      m_inst = NOP; m_pp1 = 16'h0000; m_valid = 1'b0;
    end else if (!s) begin
      m_inst  = mem_f(m_pc);
      m_pp1   = m_pc + 16'd1;
      m_valid = 1'b1;
      m_pc    = m_pc + 16'd1;
      if (m_fcnt < 65535) m_fcnt++;
    end
    if (s && !r && m_scnt < 65535) m_scnt++;
    check_model(tag);
  endtask

  initial begin
    int scnt0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;

    // Free run from reset
    step("run1", 0, 0, 0, 16'h0);
    chk("run1.inst_c", 32'(ifid_inst), 32'h1000);
    chk("run1.pp1_c",  32'(ifid_pc_plus1), 32'h0001);
    chk("run1.vld_c",  32'(ifid_valid), 32'h1);
    for (int i = 2; i <= 8; i++) step("run", 0, 0, 0, 16'h0);
    chk("run8.pc_c",   32'(pc_out), 32'h0008);
    chk("run8.inst_c", 32'(ifid_inst), 32'h1007);

    // Stall at pc=4
    rst_n = 1'b0; #1; rst_n = 1'b1; model_reset();
    for (int i = 0; i < 4; i++) step("pre_stall", 0, 0, 0, 16'h0);
`ifdef IF_PERF_CNT_EN
    scnt0 = int'(stall_cnt);
`else
    scnt0 = 0;
`endif
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 0, 0, 16'h0);
      chk("stall.pc_c",   32'(pc_out), 32'h0004);
      chk("stall.inst_c", 32'(ifid_inst), 32'h1003);
    end
`ifdef IF_PERF_CNT_EN
    chk("stall.cnt_c", 32'(stall_cnt), 32'(scnt0 + 3));
`endif
    step("unstall", 0, 0, 0, 16'h0);
    chk("unstall.inst_c", 32'(ifid_inst), 32'h1004);

    // Redirect with stall at pc=5
    step("redir", 1, 0, 1, 16'h0020);
    chk("redir.pc_c",  32'(pc_out), 32'h0020);
    chk("redir.vld_c", 32'(ifid_valid), 32'h0);
    step("redir_f", 0, 0, 0, 16'h0);
    chk("redir_f.inst_c", 32'(ifid_inst), 32'h1020);

    // Back-to-back redirects: only the last target is fetched
    step("b2b1", 0, 0, 1, 16'h0100);
    step("b2b2", 0, 1, 1, 16'h0200);
    step("b2b3", 0, 0, 0, 16'h0);
    chk("b2b.inst_c", 32'(ifid_inst), 32'h1200);

    // Flush alone at pc=6, then flush+stall at pc=6
    step("to6", 0, 0, 1, 16'h0006);
    step("flush", 0, 1, 0, 16'h0);
    chk("flush.pc_c",  32'(pc_out), 32'h0007);
    chk("flush.vld_c", 32'(ifid_valid), 32'h0);
    step("to6b", 0, 0, 1, 16'h0006);
    step("fill", 0, 0, 0, 16'h0);
    step("to6c", 0, 0, 1, 16'h0006);
    step("flush_st", 1, 1, 0, 16'h0);
    chk("flush_st.pc_c", 32'(pc_out), 32'h0006);
    chk("flush_st.inst_c", 32'(ifid_inst), 32'(NOP));

    // PC wrap
    step("toffff", 0, 0, 1, 16'hFFFF);
    step("wrap", 0, 0, 0, 16'h0);
    chk("wrap.inst_c", 32'(ifid_inst), 32'h0FFF);
    chk("wrap.pp1_c",  32'(ifid_pc_plus1), 32'h0000);
    chk("wrap.pc_c",   32'(pc_out), 32'h0000);

    // Asynchronous reset mid-cycle with pc=0x12 and valid IF/ID
    step("to11", 0, 0, 1, 16'h0011);
    step("to12", 0, 0, 0, 16'h0);
    chk("pre_rst.pc_c", 32'(pc_out), 32'h0012);
    #2;
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0055;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    #1;
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 16'h0);
    chk("post_rst.inst_c", 32'(ifid_inst), 32'h1000);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      logic s, f, r;
      logic [15:0] t;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                      : 16'($urandom);
      step("rand", s, f, r, t);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
